// File: rtl/warships_pkg.sv
// Shared types and constants for the warships board subsystem.
package warships_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_HIT   = 2'd2,
    CELL_MISS  = 2'd3
  } cell_t;

  localparam int BOARD_COLS  = 10;
  localparam int BOARD_ROWS  = 10;
  localparam int BOARD_CELLS = BOARD_COLS * BOARD_ROWS;

  localparam int HOR_TOTAL = 1344;
  localparam int VER_TOTAL = 806;

  // Origin of a RAM read, carried alongside it to route the returning data.
  typedef enum logic {
    SRC_REQ = 1'b0,
    SRC_VGA = 1'b1
  } src_t;

  // Width of an index over n requesters; never collapses to zero bits.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_mem_arbiter_if.sv
// Bus bundle around the board RAM arbiter: VGA read port, requester
// handshake, responses and the RAM-side port.
interface board_mem_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 2
);
  logic                             vblank;
  logic                             vga_rd_en;
  logic [ADDR_WIDTH-1:0]            vga_rd_addr;
  logic                             vga_rd_valid;
  logic [DATA_WIDTH-1:0]            vga_rd_data;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_rdata;
  logic                             mem_en;
  logic                             mem_we;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [DATA_WIDTH-1:0]            mem_wdata;
  logic [DATA_WIDTH-1:0]            mem_rdata;

  // Arbiter side.
  modport slave (
    input  vblank, vga_rd_en, vga_rd_addr,
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_rdata,
    output vga_rd_valid, vga_rd_data, req_ready, rsp_valid, rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Everything around the arbiter: VGA, game logic and the RAM.
  modport master (
    output vblank, vga_rd_en, vga_rd_addr,
    output req_valid, req_we, req_addr, req_wdata,
    output mem_rdata,
    input  vga_rd_valid, vga_rd_data, req_ready, rsp_valid, rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/board_mem_arbiter_rr_arbiter.sv
// Round-robin grant over an eligibility vector. The search starts at the
// pointer and wraps; the pointer moves just past each winner.
module rr_arbiter
  import warships_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] eligible,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   ptr
);

  logic [PTR_W-1:0]   ptr_reg;
  logic [PTR_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_elig;

  // Requesters at or above the pointer get first look.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign upper_mask[gi] = (ptr_reg <= PTR_W'(gi));
  end

  assign upper_elig = eligible & upper_mask;

  // Lowest eligible at/above the pointer, else lowest overall (the wrap).
  always_comb begin
    if (upper_elig != '0) begin
      grant = upper_elig & (-upper_elig);
    end else begin
      grant = eligible & (-eligible);
    end
  end

  // Next pointer is one past the winner; unchanged with no grant.
  always_comb begin
    ptr_next = ptr_reg;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/board_mem_arbiter.sv
// Board-state RAM arbiter: VGA reads take absolute priority, game-logic
// requesters share the rest round-robin, optionally with writes held back
// to vertical blanking. Reads return data a fixed two cycles after grant.
module board_mem_arbiter
  import warships_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 2,
  parameter bit WR_IN_VBLANK = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  board_mem_arbiter_if.slave  bus
);

  localparam int ID_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       rr_ptr;
  logic                  any_grant;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [ID_W-1:0]       win_id;
  logic                  rd_issue;
  src_t                  rd_src;

  logic                  mem_en_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;

  // Read tag pipeline: index 0 aligns with the RAM access, 1 with its data.
  logic                  tag_valid_reg [2];
  src_t                  tag_src_reg   [2];
  logic [ID_W-1:0]       tag_id_reg    [2];

  // A requester competes only when VGA is idle and, for writes, only when
  // the frame is in blanking (if gating is enabled). Nothing is granted in reset.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign eligible[gi] = rst_n && !bus.vga_rd_en && bus.req_valid[gi] &&
                          (!bus.req_we[gi] || bus.vblank || !WR_IN_VBLANK);
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant),
    .ptr      (rr_ptr)
  );

  assign bus.req_ready = grant;
  assign any_grant     = |grant;

  // Select the winning requester's access fields from the one-hot grant.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_we    = bus.req_we[i];
        win_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        win_id    = ID_W'(i);
      end
    end
  end

  assign rd_issue = bus.vga_rd_en || (any_grant && !win_we);
  assign rd_src   = bus.vga_rd_en ? SRC_VGA : SRC_REQ;

  // Register the winning access onto the RAM port; addr/wdata hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (bus.vga_rd_en) begin
      mem_en_reg    <= 1'b1;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= bus.vga_rd_addr;
    end else if (any_grant) begin
      mem_en_reg    <= 1'b1;
      mem_we_reg    <= win_we;
      mem_addr_reg  <= win_addr;
      mem_wdata_reg <= win_wdata;
    end else begin
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
    end
  end

  // Carry each read's source through the RAM latency; reset drops them all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_reg[0] <= 1'b0;
      tag_valid_reg[1] <= 1'b0;
      tag_src_reg[0]   <= SRC_REQ;
      tag_src_reg[1]   <= SRC_REQ;
      tag_id_reg[0]    <= '0;
      tag_id_reg[1]    <= '0;
    end else begin
      tag_valid_reg[0] <= rd_issue;
      tag_src_reg[0]   <= rd_src;
      tag_id_reg[0]    <= win_id;
      tag_valid_reg[1] <= tag_valid_reg[0];
      tag_src_reg[1]   <= tag_src_reg[0];
      tag_id_reg[1]    <= tag_id_reg[0];
    end
  end

  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  // RAM data is shared; only the strobes are steered by the tag.
  assign bus.vga_rd_valid = tag_valid_reg[1] && (tag_src_reg[1] == SRC_VGA);
  assign bus.vga_rd_data  = bus.mem_rdata;
  assign bus.rsp_rdata    = bus.mem_rdata;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign bus.rsp_valid[gi] = tag_valid_reg[1] && (tag_src_reg[1] == SRC_REQ) &&
                               (tag_id_reg[1] == ID_W'(gi));
  end

  // The grant is one-hot or empty and the pointer stays in range.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(grant));
      assert (int'(rr_ptr) < NUM_REQ);
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a transaction-level model that
// tracks board contents, arbitration order and expected read returns.
module tb_board_mem_arbiter;
  import warships_pkg::*;

  localparam int NR = 3;
  localparam int AW = 7;
  localparam int DW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic ram_fill;

  board_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  board_mem_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_IN_VBLANK(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Board RAM with one-cycle registered read (read-before-write).
  logic [DW-1:0] ram [0:127];
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 128; i++) ram[i] <= 2'(i % 4);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Model: expected read return = board contents at the moment of grant.
  typedef struct {
    bit v;
    bit vga;
    int id;
    int data;
  } exp_t;

  int   shadow [0:127];
  int   m_ptr, m_addr, m_wdata;
  bit   m_en, m_we;
  exp_t s1, s2;

  always @(negedge clk) begin
    int g;
    int idx;
    int a;
    if (ram_fill) for (int i = 0; i < 128; i++) shadow[i] = i % 4;
    if (!rst_n) begin
      check("rst_mem_en",   int'(bus.mem_en), 0);
      check("rst_mem_we",   int'(bus.mem_we), 0);
      check("rst_mem_addr", int'(bus.mem_addr), 0);
      check("rst_mem_wdata", int'(bus.mem_wdata), 0);
      check("rst_vga_valid", int'(bus.vga_rd_valid), 0);
      check("rst_rsp_valid", int'(bus.rsp_valid), 0);
      check("rst_req_ready", int'(bus.req_ready), 0);
      m_ptr = 0; m_en = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      s1 = '{default: 0};
      s2 = '{default: 0};
    end else begin
      // Returns due this cycle.
      check("vga_rd_valid", int'(bus.vga_rd_valid), (s2.v && s2.vga) ? 1 : 0);
      if (s2.v && s2.vga) check("vga_rd_data", int'(bus.vga_rd_data), s2.data);
      check("rsp_valid", int'(bus.rsp_valid), (s2.v && !s2.vga) ? (1 << s2.id) : 0);
      if (s2.v && !s2.vga) check("rsp_rdata", int'(bus.rsp_rdata), s2.data);
      // RAM port carries last cycle's winner.
      check("mem_en",    int'(bus.mem_en), int'(m_en));
      check("mem_we",    int'(bus.mem_we), int'(m_we));
      check("mem_addr",  int'(bus.mem_addr), m_addr);
      check("mem_wdata", int'(bus.mem_wdata), m_wdata);
      // Who should win now.
      g = -1;
      if (!bus.vga_rd_en) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (g < 0 && bus.req_valid[idx] && (!bus.req_we[idx] || bus.vblank)) g = idx;
        end
      end
      check("req_ready", int'(bus.req_ready), (g >= 0) ? (1 << g) : 0);
      // Advance the model by one cycle.
      s2 = s1;
      s1 = '{default: 0};
      if (bus.vga_rd_en) begin
        a = int'(bus.vga_rd_addr);
        m_en = 1; m_we = 0; m_addr = a;
        s1 = '{v: 1, vga: 1, id: 0, data: shadow[a]};
      end else if (g >= 0) begin
        a = int'(bus.req_addr[g*AW +: AW]);
        m_en = 1; m_we = bus.req_we[g]; m_addr = a;
        m_wdata = int'(bus.req_wdata[g*DW +: DW]);
        if (m_we) shadow[a] = m_wdata;
        else s1 = '{v: 1, vga: 0, id: g, data: shadow[a]};
        m_ptr = (g + 1) % NR;
      end else begin
        m_en = 0; m_we = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input int addr, input int wd);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = AW'(addr);
    bus.req_wdata[i*DW +: DW] = DW'(wd);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    ram_fill = 1'b1;
    bus.vblank = 1'b1;
    bus.vga_rd_en = 1'b0;
    bus.vga_rd_addr = '0;
    bus.req_valid = '1;
    bus.req_we = '0;
    bus.req_addr = {7'd12, 7'd11, 7'd10};
    bus.req_wdata = '0;

    // Reset held with every requester asking.
    @(negedge clk);
    @(negedge clk);
    check("t1_rst_mem_en", int'(bus.mem_en), 0);
    check("t1_rst_ready", int'(bus.req_ready), 0);
    tick();
    ram_fill = 1'b0;
    rst_n = 1'b1;

    // Round robin from pointer 0: 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_rr_grant", int'(bus.req_ready), 1 << (k % 3));
      $display("rr cycle %0d ready=%b", k, bus.req_ready);
      tick();
    end

    // VGA priority, cell 42 holds CELL_HIT.
    bus.vga_rd_en = 1'b1;
    bus.vga_rd_addr = 7'd42;
    @(negedge clk);
    check("t2_vga_blocks", int'(bus.req_ready), 0);
    tick();
    bus.vga_rd_en = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    check("t2_mem_en", int'(bus.mem_en), 1);
    check("t2_mem_addr", int'(bus.mem_addr), 42);
    tick();
    @(negedge clk);
    check("t2_vga_valid", int'(bus.vga_rd_valid), 1);
    check("t2_vga_data", int'(bus.vga_rd_data), 2);
    $display("vga read addr 42 data=%0d", bus.vga_rd_data);
    tick();

    // Write gated outside vblank.
    bus.vblank = 1'b0;
    set_req(0, 1'b1, 1'b1, 5, 1);
    set_req(1, 1'b1, 1'b0, 7, 0);
    @(negedge clk);
    check("t4_read_passes", int'(bus.req_ready), 3'b010);
    tick();
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check("t4_write_held", int'(bus.req_ready), 0);
    tick();
    bus.vblank = 1'b1;
    @(negedge clk);
    check("t4_write_granted", int'(bus.req_ready), 3'b001);
    tick();
    bus.req_valid = '0;
    bus.req_we = '0;
    @(negedge clk);
    check("t4_mem_we", int'(bus.mem_we), 1);
    check("t4_mem_addr", int'(bus.mem_addr), 5);
    check("t4_mem_wdata", int'(bus.mem_wdata), 1);
    $display("write addr 5 data %0d committed in vblank", bus.mem_wdata);
    tick();
    tick();
    tick();

    // VGA interleaved with req2 reads.
    set_req(2, 1'b1, 1'b0, 33, 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        bus.vga_rd_en = (k % 2 == 0);
        bus.vga_rd_addr = AW'(20 + k);
      end else begin
        bus.vga_rd_en = 1'b0;
        bus.req_valid = '0;
      end
      @(negedge clk);
      if (k < 4) check("t5_interleave", int'(bus.req_ready), (k % 2 == 0) ? 0 : 3'b100);
      if (bus.rsp_valid[2]) cnt++;
      tick();
    end
    check("t5_rsp_count", cnt, 2);
    $display("interleave: req2 responses=%0d", cnt);

    // Reset right after a grant to req1.
    set_req(1, 1'b1, 1'b0, 60, 0);
    @(negedge clk);
    check("t6_grant_req1", int'(bus.req_ready), 3'b010);
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_rsp", int'(bus.rsp_valid), 0);
      tick();
    end
    rst_n = 1'b1;
    bus.req_addr = {7'd12, 7'd11, 7'd10};
    bus.req_we = '0;
    bus.req_valid = '1;
    @(negedge clk);
    check("t6_ptr_zero", int'(bus.req_ready), 3'b001);
    check("t6_no_stale_rsp", int'(bus.rsp_valid), 0);
    $display("post-reset grant ready=%b", bus.req_ready);
    tick();
    for (int k = 0; k < 4; k++) tick();
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
